// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - EX/MEM inputs, data RAM port and MEM/WB outputs of the memory stage
interface mem_access_unit_if #(
  parameter int DATA_W = 128,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 16,
  parameter int REG_W  = 4
);
  logic              regw_M;
  logic              memw_M;
  logic              regmem_M;
  logic              vect_M;
  logic [REG_W-1:0]  regScr_M;
  logic [DATA_W-1:0] ALUrslt_M;
  logic [DATA_W-1:0] address_M;
  logic              stall_M;

  logic [ADDR_W-1:0] mem_address;
  logic [WORD_W-1:0] mem_data;
  logic              mem_wren;
  logic [WORD_W-1:0] mem_q;

  logic              regw_W;
  logic              regmem_W;
  logic              vect_W;
  logic [REG_W-1:0]  regScr_W;
  logic [DATA_W-1:0] ALUrslt_W;
  logic [DATA_W-1:0] memrslt_W;

  modport slave (
    input  regw_M, memw_M, regmem_M, vect_M, regScr_M, ALUrslt_M, address_M,
    output stall_M,
    output mem_address, mem_data, mem_wren,
    input  mem_q,
    output regw_W, regmem_W, vect_W, regScr_W, ALUrslt_W, memrslt_W
  );

  modport master (
    output regw_M, memw_M, regmem_M, vect_M, regScr_M, ALUrslt_M, address_M,
    input  stall_M,
    input  mem_address, mem_data, mem_wren,
    output mem_q,
    input  regw_W, regmem_W, vect_W, regScr_W, ALUrslt_W, memrslt_W
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-stage sequencer for scalar and 4-lane vector loads/stores
module mem_access_unit #(
  parameter int DATA_W = 128,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  bus
);
  localparam int LANES = DATA_W / WORD_W;
  localparam logic [1:0] LAST_BEAT = 2'(LANES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LD_WAIT,
    VST,
    VLD,
    VLD_DRAIN
  } state_t;

  state_t            state, state_nx;
  logic [1:0]        beat, beat_nx;

  logic              stall_c;
  logic              wren_c;
  logic              w_cap;
  logic              w_bub;
  logic              mem_clr;
  logic              ld_scalar;
  logic              lane_cap;
  logic              drain;

  logic              regw_r, regmem_r, vect_r;
  logic [REG_W-1:0]  regScr_r;
  logic [DATA_W-1:0] ALUrslt_r;
  logic [DATA_W-1:0] memrslt_r;
  // Lanes 0..LANES-2 of a vector load; the last lane comes straight from mem_q at drain.
  logic [DATA_W-WORD_W-1:0] vld_buf;

  logic              is_st, is_ld;
  logic [ADDR_W-1:0] base;
  logic              unused_addr_hi;

  assign base           = bus.address_M[ADDR_W-1:0];
  assign unused_addr_hi = ^bus.address_M[DATA_W-1:ADDR_W];
  // A store wins when both memw_M and regmem_M are set.
  assign is_st = bus.memw_M;
  assign is_ld = bus.regmem_M & ~bus.memw_M;

  always_comb begin
    state_nx  = state;
    beat_nx   = beat;
    stall_c   = 1'b0;
    wren_c    = 1'b0;
    w_cap     = 1'b0;
    w_bub     = 1'b0;
    mem_clr   = 1'b0;
    ld_scalar = 1'b0;
    lane_cap  = 1'b0;
    drain     = 1'b0;

    case (state)
      IDLE: begin
        if (is_st) begin
          wren_c = 1'b1;
          if (bus.vect_M) begin
            stall_c  = 1'b1;
            w_bub    = 1'b1;
            state_nx = VST;
            beat_nx  = 2'd1;
          end else begin
            w_cap   = 1'b1;
            mem_clr = 1'b1;
          end
        end else if (is_ld) begin
          stall_c = 1'b1;
          w_bub   = 1'b1;
          if (bus.vect_M) begin
            state_nx = VLD;
            beat_nx  = 2'd1;
          end else begin
            state_nx = LD_WAIT;
          end
        end else begin
          w_cap   = 1'b1;
          mem_clr = 1'b1;
        end
      end

      LD_WAIT: begin
        w_cap     = 1'b1;
        ld_scalar = 1'b1;
        state_nx  = IDLE;
      end

      VST: begin
        wren_c = 1'b1;
        if (beat == LAST_BEAT) begin
          w_cap    = 1'b1;
          mem_clr  = 1'b1;
          state_nx = IDLE;
          beat_nx  = 2'd0;
        end else begin
          stall_c = 1'b1;
          w_bub   = 1'b1;
          beat_nx = beat + 2'd1;
        end
      end

      VLD: begin
        stall_c  = 1'b1;
        w_bub    = 1'b1;
        lane_cap = 1'b1;
        if (beat == LAST_BEAT) begin
          state_nx = VLD_DRAIN;
          beat_nx  = 2'd0;
        end else begin
          beat_nx = beat + 2'd1;
        end
      end

      VLD_DRAIN: begin
        w_cap    = 1'b1;
        drain    = 1'b1;
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
        beat_nx  = 2'd0;
      end
    endcase
  end

  // Gated by rst so a pending op on *_M cannot stall or write while reset is held.
  assign bus.stall_M     = rst & stall_c;
  assign bus.mem_wren    = rst & wren_c;
  assign bus.mem_address = base + ADDR_W'(beat);
  assign bus.mem_data    = bus.ALUrslt_M[beat*WORD_W +: WORD_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      beat      <= 2'd0;
      regw_r    <= 1'b0;
      regmem_r  <= 1'b0;
      vect_r    <= 1'b0;
      regScr_r  <= '0;
      ALUrslt_r <= '0;
      memrslt_r <= '0;
      vld_buf   <= '0;
    end else begin
      state <= state_nx;
      beat  <= beat_nx;

      if (w_cap) begin
        regw_r    <= bus.regw_M;
        regmem_r  <= bus.regmem_M;
        vect_r    <= bus.vect_M;
        regScr_r  <= bus.regScr_M;
        ALUrslt_r <= bus.ALUrslt_M;
      end else if (w_bub) begin
        regw_r   <= 1'b0;
        regmem_r <= 1'b0;
        vect_r   <= 1'b0;
      end

      if (mem_clr) begin
        memrslt_r <= '0;
      end else if (ld_scalar) begin
        memrslt_r <= {{(DATA_W-WORD_W){1'b0}}, bus.mem_q};
      end else if (drain) begin
        memrslt_r <= {bus.mem_q, vld_buf};
      end

      // Shifting in from the top leaves lane 0 in the low word after LANES-1 beats.
      if (lane_cap) begin
        vld_buf <= {bus.mem_q, vld_buf[DATA_W-WORD_W-1:WORD_W]};
      end
    end
  end

  assign bus.regw_W    = regw_r;
  assign bus.regmem_W  = regmem_r;
  assign bus.vect_W    = vect_r;
  assign bus.regScr_W  = regScr_r;
  assign bus.ALUrslt_W = ALUrslt_r;
  assign bus.memrslt_W = memrslt_r;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.DATA_W(128), .WORD_W(32), .ADDR_W(16), .REG_W(4)) bus();

  mem_access_unit #(.DATA_W(128), .WORD_W(32), .ADDR_W(16), .REG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] tb_ram    [0:65535];
  logic [31:0] model_ram [0:65535];

  always @(posedge clk) begin
    if (bus.mem_wren) tb_ram[bus.mem_address] <= bus.mem_data;
    bus.mem_q <= tb_ram[bus.mem_address];
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [127:0] m_alu = '0;
  logic [3:0]   m_scr = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic drive(input logic rw, mw, rm, vc, input logic [3:0] scr,
                       input logic [127:0] alu, input logic [15:0] base);
    bus.regw_M    = rw;
    bus.memw_M    = mw;
    bus.regmem_M  = rm;
    bus.vect_M    = vc;
    bus.regScr_M  = scr;
    bus.ALUrslt_M = alu;
    bus.address_M = {$urandom, $urandom, $urandom, 16'($urandom), base};
  endtask

  // Called 1 time unit after a rising edge; returns with the op retired, same phase.
  task automatic do_op(input logic rw, mw, rm, vc, input logic [3:0] scr,
                       input logic [127:0] alu, input logic [15:0] base, output int stalls);
    logic is_st, is_ld;
    int nacc, ncyc;
    logic [127:0] exp_mem;
    logic [15:0] a;
    is_st   = mw;
    is_ld   = rm & ~mw;
    nacc    = vc ? 4 : 1;
    ncyc    = is_st ? nacc : (is_ld ? nacc + 1 : 1);
    exp_mem = '0;
    stalls  = 0;
    drive(rw, mw, rm, vc, scr, alu, base);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      a = base + 16'(c);
      if (bus.stall_M) stalls++;
      chk("stall_M", 128'(bus.stall_M), 128'(c != ncyc - 1));
      chk("mem_wren", 128'(bus.mem_wren), 128'(is_st));
      if ((is_st || is_ld) && c < nacc) chk("mem_address", 128'(bus.mem_address), 128'(a));
      if (is_st) begin
        chk("mem_data", 128'(bus.mem_data), 128'(alu[32*c +: 32]));
        model_ram[a] = alu[32*c +: 32];
      end
      if (is_ld && c < nacc) exp_mem[32*c +: 32] = model_ram[a];
      @(posedge clk);
      #1;
      if (c != ncyc - 1) begin
        chk("bubble_regw_W", 128'(bus.regw_W), 128'(0));
        chk("bubble_regmem_W", 128'(bus.regmem_W), 128'(0));
        chk("bubble_vect_W", 128'(bus.vect_W), 128'(0));
        chk("hold_ALUrslt_W", bus.ALUrslt_W, m_alu);
        chk("hold_regScr_W", 128'(bus.regScr_W), 128'(m_scr));
      end
    end
    chk("regw_W", 128'(bus.regw_W), 128'(rw));
    chk("regmem_W", 128'(bus.regmem_W), 128'(rm));
    chk("vect_W", 128'(bus.vect_W), 128'(vc));
    chk("regScr_W", 128'(bus.regScr_W), 128'(scr));
    chk("ALUrslt_W", bus.ALUrslt_W, alu);
    chk("memrslt_W", bus.memrslt_W, exp_mem);
    m_alu = alu;
    m_scr = scr;
  endtask

  typedef struct {
    logic         rw, mw, rm, vc;
    logic [3:0]   scr;
    logic [127:0] alu;
    logic [15:0]  base;
    int           exp_stalls;
    logic [127:0] exp_mem;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int st;
    logic [31:0] v;

    for (int i = 0; i < 65536; i++) begin
      v = $urandom;
      tb_ram[i]    = v;
      model_ram[i] = v;
    end

    vecs.push_back('{0, 1, 0, 0, 4'd0, 128'hDEADBEEF, 16'h0010, 0, 128'h0});
    vecs.push_back('{1, 0, 1, 0, 4'd5, 128'h0, 16'h0010, 1, 128'hDEADBEEF});
    vecs.push_back('{0, 1, 0, 1, 4'd0, {32'd44, 32'd33, 32'd22, 32'd11}, 16'h0020, 3, 128'h0});
    vecs.push_back('{1, 0, 1, 1, 4'd7, 128'h0, 16'h0020, 4, {32'd44, 32'd33, 32'd22, 32'd11}});
    vecs.push_back('{0, 1, 0, 1, 4'd0, {32'hD, 32'hC, 32'hB, 32'hA}, 16'hFFFE, 3, 128'h0});
    vecs.push_back('{1, 0, 0, 0, 4'd3, 128'h0000FFFF, 16'h0000, 0, 128'h0});
    vecs.push_back('{1, 0, 1, 1, 4'd9, 128'h0, 16'hFFFE, 4, {32'hD, 32'hC, 32'hB, 32'hA}});
    vecs.push_back('{0, 1, 1, 1, 4'd2, {32'h4, 32'h3, 32'h2, 32'h1}, 16'h0040, 3, 128'h0});
    vecs.push_back('{1, 0, 1, 0, 4'd1, 128'h0, 16'h0043, 1, 128'h4});

    drive(1, 1, 1, 1, 4'hF, '1, 16'h0030);
    #12;
    chk("rst_stall_M", 128'(bus.stall_M), 128'(0));
    chk("rst_mem_wren", 128'(bus.mem_wren), 128'(0));
    chk("rst_regw_W", 128'(bus.regw_W), 128'(0));
    chk("rst_ALUrslt_W", bus.ALUrslt_W, 128'(0));
    chk("rst_memrslt_W", bus.memrslt_W, 128'(0));
    drive(0, 0, 0, 0, 4'd0, '0, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      do_op(vecs[i].rw, vecs[i].mw, vecs[i].rm, vecs[i].vc, vecs[i].scr,
            vecs[i].alu, vecs[i].base, st);
      chk($sformatf("vec%0d_stalls", i), 128'(st), 128'(vecs[i].exp_stalls));
      chk($sformatf("vec%0d_memrslt", i), bus.memrslt_W, vecs[i].exp_mem);
    end

    // Reset landing in the middle of a vector load, during beat 2.
    drive(1, 0, 1, 1, 4'd6, 128'h1234, 16'h0100);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_stall_M", 128'(bus.stall_M), 128'(0));
    chk("midrst_mem_wren", 128'(bus.mem_wren), 128'(0));
    chk("midrst_regw_W", 128'(bus.regw_W), 128'(0));
    chk("midrst_regScr_W", 128'(bus.regScr_W), 128'(0));
    chk("midrst_ALUrslt_W", bus.ALUrslt_W, 128'(0));
    chk("midrst_memrslt_W", bus.memrslt_W, 128'(0));
    drive(0, 0, 0, 0, 4'd0, '0, 16'h0);
    m_alu = '0;
    m_scr = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_op(1, 0, 1, 1, 4'd8, 128'h0, 16'h0020, st);
    chk("post_rst_vld_stalls", 128'(st), 128'(4));

    for (int k = 0; k < 40; k++) begin
      logic [15:0] b;
      b = ($urandom_range(0, 1) == 1) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                      : 16'($urandom_range(0, 63));
      do_op(1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
            1'($urandom), 4'($urandom), {$urandom, $urandom, $urandom, $urandom}, b, st);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
